// File: rtl/requant_pack.sv
// requant_pack: int32 accumulator -> int8 requantizer and 4-lane packer.
//
// Sits directly downstream of piped_mac. Each 32-bit signed accumulator is
// scaled by an unsigned multiplier, then arithmetically right-shifted with
// round-half-up. The zero point is added and the result is saturated to int8.
// Four results are packed per 32-bit output word; lane 0 is the first result.
// TLAST on the input flushes a partial word, and the unfilled lanes of that
// word are zero with a cleared TKEEP bit.
//
// Optional build macro: REQUANT_RELU_EN. When it is defined, the saturated
// result is clamped from below at CFG_ZP, which is a fused ReLU in the
// quantized domain.
//
// Ports:
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   SD_AXIS_*            slave stream of signed 32-bit accumulators
//   CFG_MULT/SHIFT/ZP    quasi-static scale, shift (0..31), signed zero point
//   MO_AXIS_*            master stream of packed int8 words with TKEEP/TLAST
//
// Pipeline: stage 1 multiply, stage 2 round/zero-point/saturate, stage 3 pack.
// A single global enable stalls every stage while an output word is held.
module requant_pack #(
  parameter int MULT_W = 16,
  parameter int LANES  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [31:0]       SD_AXIS_TDATA,
  input  logic              SD_AXIS_TVALID,
  input  logic              SD_AXIS_TLAST,
  output logic              SD_AXIS_TREADY,
  input  logic [MULT_W-1:0] CFG_MULT,
  input  logic [4:0]        CFG_SHIFT,
  input  logic [7:0]        CFG_ZP,
  output logic [31:0]       MO_AXIS_TDATA,
  output logic [3:0]        MO_AXIS_TKEEP,
  output logic              MO_AXIS_TLAST,
  output logic              MO_AXIS_TVALID,
  input  logic              MO_AXIS_TREADY
);

  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  function automatic logic signed [48:0] round_shift(input logic signed [47:0] p,
                                                     input logic [4:0] sh);
    logic signed [48:0] x;
    x = {p[47], p};
    // One guard bit above the product so that adding the half-LSB cannot wrap.
    if (sh != 5'd0) x = (x + (49'sd1 <<< (sh - 5'd1))) >>> sh;
    return x;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [48:0] v);
    if (v > 49'sd127)       return 8'sh7F;
    else if (v < -49'sd128) return 8'sh80;
    else                    return v[7:0];
  endfunction

  logic en;
  logic in_xfer;

  // A held output word is the only thing that ever stalls the pipeline.
  assign en             = !(MO_AXIS_TVALID && !MO_AXIS_TREADY);
  assign SD_AXIS_TREADY = en;
  assign in_xfer        = SD_AXIS_TVALID && en;

  // ---- stage 1: scale multiply ----
  logic signed [47:0] acc_ext, mult_ext;
  logic               vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic signed [47:0] prod_p1_q, prod_p1_d;

  assign acc_ext  = {{16{SD_AXIS_TDATA[31]}}, SD_AXIS_TDATA};
  assign mult_ext = {{(48-MULT_W){1'b0}}, CFG_MULT};

  always_comb begin
    vld_p1_d  = vld_p1_q;
    last_p1_d = last_p1_q;
    prod_p1_d = prod_p1_q;
    if (en) begin
      vld_p1_d  = in_xfer;
      last_p1_d = in_xfer && SD_AXIS_TLAST;
      if (in_xfer) prod_p1_d = acc_ext * mult_ext;
    end
  end

  // ---- stage 2: round, zero point, saturate ----
  logic signed [48:0] rs_p2, v_p2;
  logic signed [7:0]  qs_p2;
  logic               vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic signed [7:0]  q_p2_q, q_p2_d;

  always_comb begin
    rs_p2 = round_shift(prod_p1_q, CFG_SHIFT);
    v_p2  = rs_p2 + {{41{CFG_ZP[7]}}, CFG_ZP};
    qs_p2 = sat8(v_p2);
`ifdef REQUANT_RELU_EN
    if (qs_p2 < $signed(CFG_ZP)) qs_p2 = $signed(CFG_ZP);
`else
`endif
    vld_p2_d  = vld_p2_q;
    last_p2_d = last_p2_q;
    q_p2_d    = q_p2_q;
    if (en) begin
      vld_p2_d  = vld_p1_q;
      last_p2_d = vld_p1_q && last_p1_q;
      if (vld_p1_q) q_p2_d = qs_p2;
    end
  end

  // ---- stage 3: lane packer and output register ----
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] lane_q, lane_d;
  logic [3:0]  keep_q, keep_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic [31:0] word;
  logic [3:0]  keep_w;

  always_comb begin
    word                     = lane_q;
    word[{cnt_q, 3'b000} +: 8] = q_p2_q;
    keep_w                   = keep_q;
    keep_w[cnt_q]            = 1'b1;

    cnt_d    = cnt_q;
    lane_d   = lane_q;
    keep_d   = keep_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (en) begin
      // en implies any presented word is being accepted this cycle.
      tvalid_d = 1'b0;
      if (vld_p2_q) begin
        if (cnt_q == LAST_LANE || last_p2_q) begin
          tdata_d  = word;
          tkeep_d  = keep_w;
          tlast_d  = last_p2_q;
          tvalid_d = 1'b1;
          cnt_d    = 2'd0;
          lane_d   = 32'd0;
          keep_d   = 4'd0;
        end else begin
          lane_d = word;
          keep_d = keep_w;
          cnt_d  = cnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      cnt_q     <= 2'd0;
      lane_q    <= 32'd0;
      keep_q    <= 4'd0;
      tdata_q   <= 32'd0;
      tkeep_q   <= 4'd0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      keep_q    <= keep_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
    end
  end

  always_ff @(posedge ACLK) begin
    prod_p1_q <= prod_p1_d;
    q_p2_q    <= q_p2_d;
  end

  assign MO_AXIS_TDATA  = tdata_q;
  assign MO_AXIS_TKEEP  = tkeep_q;
  assign MO_AXIS_TLAST  = tlast_q;
  assign MO_AXIS_TVALID = tvalid_q;

endmodule

// File: tb/tb_requant_pack.sv
module tb_requant_pack;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] SD_AXIS_TDATA;
  logic        SD_AXIS_TVALID;
  logic        SD_AXIS_TLAST;
  logic        SD_AXIS_TREADY;
  logic [15:0] CFG_MULT;
  logic [4:0]  CFG_SHIFT;
  logic [7:0]  CFG_ZP;
  logic [31:0] MO_AXIS_TDATA;
  logic [3:0]  MO_AXIS_TKEEP;
  logic        MO_AXIS_TLAST;
  logic        MO_AXIS_TVALID;
  logic        MO_AXIS_TREADY;

  requant_pack #(.MULT_W(16), .LANES(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .SD_AXIS_TDATA(SD_AXIS_TDATA), .SD_AXIS_TVALID(SD_AXIS_TVALID),
    .SD_AXIS_TLAST(SD_AXIS_TLAST), .SD_AXIS_TREADY(SD_AXIS_TREADY),
    .CFG_MULT(CFG_MULT), .CFG_SHIFT(CFG_SHIFT), .CFG_ZP(CFG_ZP),
    .MO_AXIS_TDATA(MO_AXIS_TDATA), .MO_AXIS_TKEEP(MO_AXIS_TKEEP),
    .MO_AXIS_TLAST(MO_AXIS_TLAST), .MO_AXIS_TVALID(MO_AXIS_TVALID),
    .MO_AXIS_TREADY(MO_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t wq[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Words seen valid and ready here are taken at the following rising edge.
  always @(negedge ACLK) begin
    if (ARESETN && MO_AXIS_TVALID && MO_AXIS_TREADY)
      wq.push_back('{d: MO_AXIS_TDATA, k: MO_AXIS_TKEEP, l: MO_AXIS_TLAST});
  end

  task automatic set_cfg(input logic [15:0] m, input logic [4:0] s, input logic [7:0] z);
    CFG_MULT = m; CFG_SHIFT = s; CFG_ZP = z;
  endtask

  task automatic send(input logic [31:0] a, input logic l);
    logic rdy;
    logic done;
    done = 1'b0;
    SD_AXIS_TDATA = a; SD_AXIS_TVALID = 1'b1; SD_AXIS_TLAST = l;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge ACLK); rdy = SD_AXIS_TREADY;
      @(posedge ACLK); #1;
      if (rdy) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: accepted=%0d required=1 for acc %h", done, a);
    end
    SD_AXIS_TVALID = 1'b0; SD_AXIS_TLAST = 1'b0;
  endtask

  task automatic wait_words(input int n, input string nm);
    for (int i = 0; i < 100 && wq.size() < n; i++) @(posedge ACLK);
    #1;
    n_tests++;
    if (wq.size() < n) begin
      n_fail++;
      $display("FAIL %s_word_count: got %0d required %0d", nm, wq.size(), n);
    end
  endtask

  task automatic test_reset;
    ARESETN = 1'b0; MO_AXIS_TREADY = 1'b1;
    SD_AXIS_TVALID = 1'b0; SD_AXIS_TLAST = 1'b0; SD_AXIS_TDATA = 32'd0;
    set_cfg(16'd16384, 5'd14, 8'd0);
    repeat (3) @(posedge ACLK);
    #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b required 0", MO_AXIS_TVALID); end
    n_tests++; if (MO_AXIS_TDATA !== 32'd0) begin n_fail++; $display("FAIL reset_tdata: got %h required 0", MO_AXIS_TDATA); end
    n_tests++; if (MO_AXIS_TKEEP !== 4'd0) begin n_fail++; $display("FAIL reset_tkeep: got %h required 0", MO_AXIS_TKEEP); end
    n_tests++; if (MO_AXIS_TLAST !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b required 0", MO_AXIS_TLAST); end
    n_tests++; if (SD_AXIS_TREADY !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b required 1", SD_AXIS_TREADY); end
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
  endtask

  // Four results with TLAST on the fourth; checks one word's data/keep/last.
  task automatic run_word4(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [31:0] exp_d);
    wq.delete();
    send(a0, 1'b0); send(a1, 1'b0); send(a2, 1'b0); send(a3, 1'b1);
    wait_words(1, nm);
    if (wq.size() >= 1) begin
      n_tests++; if (wq[0].d !== exp_d) begin n_fail++; $display("FAIL %s_tdata: got %h required %h", nm, wq[0].d, exp_d); end
      n_tests++; if (wq[0].k !== 4'hF) begin n_fail++; $display("FAIL %s_tkeep: got %h required F", nm, wq[0].k); end
      n_tests++; if (wq[0].l !== 1'b1) begin n_fail++; $display("FAIL %s_tlast: got %b required 1", nm, wq[0].l); end
    end
  endtask

  task automatic test_unity;
    set_cfg(16'd16384, 5'd14, 8'd0);
    run_word4("unity", 32'd100, -32'sd50, 32'd127, 32'd200, 32'h7F7FCE64);
  endtask

  task automatic test_rounding;
    set_cfg(16'd1, 5'd1, 8'd0);
    run_word4("round", 32'd3, -32'sd3, 32'd5, -32'sd5, 32'hFE03FF02);
  endtask

  task automatic test_partial_flush;
    set_cfg(16'd16384, 5'd14, 8'hF6);
    wq.delete();
    send(32'd20, 1'b0); send(-32'sd200, 1'b1);
    wait_words(1, "partial");
    if (wq.size() >= 1) begin
      n_tests++; if (wq[0].d !== 32'h0000800A) begin n_fail++; $display("FAIL partial_tdata: got %h required 0000800a", wq[0].d); end
      n_tests++; if (wq[0].k !== 4'h3) begin n_fail++; $display("FAIL partial_tkeep: got %h required 3", wq[0].k); end
      n_tests++; if (wq[0].l !== 1'b1) begin n_fail++; $display("FAIL partial_tlast: got %b required 1", wq[0].l); end
    end
  endtask

  // 1 * 65535 rounded by 2^16 gives 1 only if the multiplier is unsigned.
  task automatic test_mult_unsigned;
    set_cfg(16'hFFFF, 5'd16, 8'd0);
    wq.delete();
    send(32'd1, 1'b1);
    wait_words(1, "umult");
    if (wq.size() >= 1) begin
      n_tests++; if (wq[0].d !== 32'h00000001) begin n_fail++; $display("FAIL umult_tdata: got %h required 00000001", wq[0].d); end
      n_tests++; if (wq[0].k !== 4'h1) begin n_fail++; $display("FAIL umult_tkeep: got %h required 1", wq[0].k); end
    end
  endtask

  task automatic test_relu;
    set_cfg(16'd16384, 5'd14, 8'd5);
`ifdef REQUANT_RELU_EN
    run_word4("relu", -32'sd40, 32'd7, 32'd0, 32'd130, 32'h7F050C05);
`else
    run_word4("relu", -32'sd40, 32'd7, 32'd0, 32'd130, 32'h7F050CDD);
`endif
  endtask

  task automatic test_latency;
    set_cfg(16'd16384, 5'd14, 8'd0);
    wq.delete();
    send(-32'sd3, 1'b1);
    @(posedge ACLK); #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b required 0", MO_AXIS_TVALID); end
    @(posedge ACLK); #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b required 1", MO_AXIS_TVALID); end
    n_tests++; if (MO_AXIS_TDATA !== 32'h000000FD) begin n_fail++; $display("FAIL lat_tdata: got %h required 000000fd", MO_AXIS_TDATA); end
    n_tests++; if (MO_AXIS_TKEEP !== 4'h1) begin n_fail++; $display("FAIL lat_tkeep: got %h required 1", MO_AXIS_TKEEP); end
    wait_words(1, "lat");
  endtask

  task automatic test_back_to_back;
    logic        seen;
    logic [31:0] held;
    set_cfg(16'd16384, 5'd14, 8'd0);
    wq.delete();
    seen = 1'b0;
    held = 32'd0;
    MO_AXIS_TREADY = 1'b1;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
      end
      begin
        for (int i = 0; i < 60 && !seen; i++) begin
          @(posedge ACLK); #1;
          if (MO_AXIS_TVALID) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
          n_fail++; $display("FAIL bp_first_word: got valid=0 required 1");
        end else begin
          MO_AXIS_TREADY = 1'b0;
          held = MO_AXIS_TDATA;
          for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            n_tests++; if (MO_AXIS_TVALID !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b required 1", MO_AXIS_TVALID); end
            n_tests++; if (MO_AXIS_TDATA !== 32'h04030201) begin n_fail++; $display("FAIL bp_hold_data: got %h required 04030201", MO_AXIS_TDATA); end
            n_tests++; if (SD_AXIS_TREADY !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", SD_AXIS_TREADY); end
          end
          @(posedge ACLK); #1;
          MO_AXIS_TREADY = 1'b1;
        end
      end
    join
    wait_words(2, "bp");
    if (wq.size() >= 2) begin
      n_tests++; if (wq[0].d !== 32'h04030201) begin n_fail++; $display("FAIL bp_w0_data: got %h required 04030201", wq[0].d); end
      n_tests++; if (wq[0].l !== 1'b0) begin n_fail++; $display("FAIL bp_w0_last: got %b required 0", wq[0].l); end
      n_tests++; if (wq[1].d !== 32'h08070605) begin n_fail++; $display("FAIL bp_w1_data: got %h required 08070605", wq[1].d); end
      n_tests++; if (wq[1].k !== 4'hF) begin n_fail++; $display("FAIL bp_w1_keep: got %h required F", wq[1].k); end
      n_tests++; if (wq[1].l !== 1'b1) begin n_fail++; $display("FAIL bp_w1_last: got %b required 1", wq[1].l); end
    end
  endtask

  task automatic test_reset_mid_word;
    set_cfg(16'd16384, 5'd14, 8'd0);
    wq.delete();
    send(32'd10, 1'b0); send(32'd20, 1'b0);
    ARESETN = 1'b0;
    #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid: got %b required 0", MO_AXIS_TVALID); end
    n_tests++; if (MO_AXIS_TDATA !== 32'd0) begin n_fail++; $display("FAIL rstmid_tdata: got %h required 0", MO_AXIS_TDATA); end
    n_tests++; if (MO_AXIS_TKEEP !== 4'd0) begin n_fail++; $display("FAIL rstmid_tkeep: got %h required 0", MO_AXIS_TKEEP); end
    n_tests++; if (MO_AXIS_TLAST !== 1'b0) begin n_fail++; $display("FAIL rstmid_tlast: got %b required 0", MO_AXIS_TLAST); end
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'd4, 1'b1);
    wait_words(1, "rstmid");
    repeat (10) @(posedge ACLK);
    #1;
    n_tests++; if (wq.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d required 1", wq.size()); end
    if (wq.size() >= 1) begin
      n_tests++; if (wq[0].d !== 32'h04030201) begin n_fail++; $display("FAIL rstmid_tdata_w: got %h required 04030201", wq[0].d); end
      n_tests++; if (wq[0].k !== 4'hF) begin n_fail++; $display("FAIL rstmid_tkeep_w: got %h required F", wq[0].k); end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_rounding();
    test_partial_flush();
    test_mult_unsigned();
    test_relu();
    test_latency();
    test_back_to_back();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
